// File: rtl/obi_arb_pkg.sv
// Shared types and helpers for the two-requester OBI data arbiter.
package obi_arb_pkg;

    typedef logic arb_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam arb_id_t ID_CORE = 1'b0;
    localparam arb_id_t ID_DBG  = 1'b1;

    // Pick a requester among those requesting; tie_winner resolves a tie.
    function automatic arb_id_t pick_id(input logic req0, input logic req1, input arb_id_t tie_winner);
        if (req0 && req1) begin
            return tie_winner;
        end else if (req1) begin
            return ID_DBG;
        end else begin
            return ID_CORE;
        end
    endfunction

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester ids for granted-but-unanswered transactions.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             push_id_i,
    input  logic             pop_i,
    output logic             head_id_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    arb_id_t          mem_q [DEPTH];
    arb_id_t          mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_id_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state is reset; id storage is only meaningful while counted.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_id_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/obi_data_arbiter.sv
// Two-requester (core data, debug system bus) to one-target OBI arbiter.
// Responses are routed in order using an id FIFO.
// Optional performance counters: define OBI_DATA_ARBITER_PERF_EN.
module obi_data_arbiter
    import obi_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int FIXED_PRIO      = 0,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic                    s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic                    protocol_err_o
`ifdef OBI_DATA_ARBITER_PERF_EN
    ,
    output logic [31:0]             perf_gnt0_o,
    output logic [31:0]             perf_gnt1_o,
    output logic [31:0]             perf_stall_o
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e       state_q, state_d;
    arb_id_t          hold_id_q, hold_id_d;
    arb_id_t          rr_ptr_q, rr_ptr_d;
    logic             err_q, err_d;

    logic             sel_valid;
    arb_id_t          sel_id;
    logic             grant;
    logic             blocked;
    logic             pop;
    arb_id_t          head_id;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    arb_id_t          tie_winner;

    assign tie_winner = (FIXED_PRIO != 0) ? ID_DBG : rr_ptr_q;
    assign blocked    = fifo_full;
    assign pop        = s_rvalid_i && !fifo_empty;

    // Arbitration FSM: select, grant or hold the address phase, flag violations.
    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        rr_ptr_d  = rr_ptr_q;
        err_d     = err_q;
        sel_valid = 1'b0;
        sel_id    = ID_CORE;
        grant     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!blocked && (m0_req_i || m1_req_i)) begin
                    sel_valid = 1'b1;
                    sel_id    = pick_id(m0_req_i, m1_req_i, tie_winner);
                    if (s_gnt_i) begin
                        grant = 1'b1;
                    end else begin
                        hold_id_d = sel_id;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                // Mux frozen on the latched requester until it is granted.
                sel_id = hold_id_q;
                if (!blocked) begin
                    if ((hold_id_q == ID_DBG) ? m1_req_i : m0_req_i) begin
                        sel_valid = 1'b1;
                        if (s_gnt_i) begin
                            grant   = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            rr_ptr_d = ~sel_id;
        end
        if (s_rvalid_i && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            hold_id_q <= ID_CORE;
            rr_ptr_q  <= ID_CORE;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
        end
    end

    obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (grant),
        .push_id_i (sel_id),
        .pop_i     (pop),
        .head_id_o (head_id),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Address-phase mux toward the target; zero when nothing is selected.
    always_comb begin
        s_req_o   = sel_valid;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (sel_valid) begin
            s_addr_o  = (sel_id == ID_DBG) ? m1_addr_i  : m0_addr_i;
            s_we_o    = (sel_id == ID_DBG) ? m1_we_i    : m0_we_i;
            s_be_o    = (sel_id == ID_DBG) ? m1_be_i    : m0_be_i;
            s_wdata_o = (sel_id == ID_DBG) ? m1_wdata_i : m0_wdata_i;
        end
    end

    assign m0_gnt_o       = grant && (sel_id == ID_CORE);
    assign m1_gnt_o       = grant && (sel_id == ID_DBG);
    assign m0_rvalid_o    = pop && (head_id == ID_CORE);
    assign m1_rvalid_o    = pop && (head_id == ID_DBG);
    assign m0_rdata_o     = s_rdata_i;
    assign m1_rdata_o     = s_rdata_i;
    assign protocol_err_o = err_q;

    // A response in the grant cycle of the same transaction is unsupported.
    a_no_same_cycle_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(s_rvalid_i && fifo_empty && grant));

    a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_count <= CNT_W'(MAX_OUTSTANDING));

`ifdef OBI_DATA_ARBITER_PERF_EN
    logic [31:0] perf_gnt0_q, perf_gnt0_d;
    logic [31:0] perf_gnt1_q, perf_gnt1_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating event counters.
    always_comb begin
        perf_gnt0_d  = perf_gnt0_q;
        perf_gnt1_d  = perf_gnt1_q;
        perf_stall_d = perf_stall_q;
        if (m0_gnt_o) perf_gnt0_d = sat_inc(perf_gnt0_q);
        if (m1_gnt_o) perf_gnt1_d = sat_inc(perf_gnt1_q);
        if ((m0_req_i || m1_req_i) && !grant) perf_stall_d = sat_inc(perf_stall_q);
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_gnt0_q  <= '0;
            perf_gnt1_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_gnt0_q  <= perf_gnt0_d;
            perf_gnt1_q  <= perf_gnt1_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_gnt0_o  = perf_gnt0_q;
    assign perf_gnt1_o  = perf_gnt1_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Scoreboard bench for obi_data_arbiter (round-robin and fixed-priority builds).
module tb_obi_data_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic id;
        txn_t t;
    } gexp_t;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_be;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_be;
    logic        s_req, s_gnt, s_we, s_rvalid, perr;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;

    logic        fp_m0_req, fp_m1_req, fp_m0_gnt, fp_m1_gnt, fp_m0_rvalid, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic        fp_s_req, fp_s_we, fp_s_rvalid, fp_perr, fp_prev;
    logic [3:0]  fp_s_be;

    txn_t        req_q0[$], req_q1[$];
    gexp_t       exp_g_q[$];
    logic [31:0] exp_r0_q[$], exp_r1_q[$];
    rsp_t        tgt_q[$];
    int          gnt_cyc_q[$];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   tgt_lat = 1;
    logic inj_rvalid = 1'b0;

    obi_data_arbiter #(
        .MAX_OUTSTANDING(2), .FIXED_PRIO(0), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
        .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata), .protocol_err_o(perr)
    );

    obi_data_arbiter #(
        .MAX_OUTSTANDING(2), .FIXED_PRIO(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)
    ) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(fp_m0_req), .m0_gnt_o(fp_m0_gnt), .m0_addr_i(32'h10), .m0_we_i(1'b0),
        .m0_be_i(4'hF), .m0_wdata_i(32'h0), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
        .m1_req_i(fp_m1_req), .m1_gnt_o(fp_m1_gnt), .m1_addr_i(32'h20), .m1_we_i(1'b0),
        .m1_be_i(4'hF), .m1_wdata_i(32'h0), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
        .s_req_o(fp_s_req), .s_gnt_i(1'b1), .s_addr_o(fp_s_addr), .s_we_o(fp_s_we), .s_be_o(fp_s_be),
        .s_wdata_o(fp_s_wdata), .s_rvalid_i(fp_s_rvalid), .s_rdata_i(32'h0000_5A5A),
        .protocol_err_o(fp_perr)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexp(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic w,
                         input logic [3:0] b, input logic [31:0] d);
        txn_t  t;
        gexp_t g;
        t.addr = a; t.we = w; t.be = b; t.wdata = d;
        g.id = id; g.t = t;
        if (id) begin
            req_q1.push_back(t);
            exp_r1_q.push_back(~a);
        end else begin
            req_q0.push_back(t);
            exp_r0_q.push_back(~a);
        end
        exp_g_q.push_back(g);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((req_q0.size() + req_q1.size() + exp_g_q.size() + exp_r0_q.size()
                + exp_r1_q.size() + tgt_q.size()) != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk(name, 32'(n < 300), 32'd1);
    endtask

    // Requester models: hold request with the head transaction until granted.
    initial begin
        m0_req = 0; m0_addr = 0; m0_we = 0; m0_be = 0; m0_wdata = 0;
        m1_req = 0; m1_addr = 0; m1_we = 0; m1_be = 0; m1_wdata = 0;
        forever begin
            @(posedge clk);
            #2;
            if (req_q0.size() != 0) begin
                m0_req = 1; m0_addr = req_q0[0].addr; m0_we = req_q0[0].we;
                m0_be = req_q0[0].be; m0_wdata = req_q0[0].wdata;
            end else begin
                m0_req = 0; m0_addr = 0; m0_we = 0; m0_be = 0; m0_wdata = 0;
            end
            if (req_q1.size() != 0) begin
                m1_req = 1; m1_addr = req_q1[0].addr; m1_we = req_q1[0].we;
                m1_be = req_q1[0].be; m1_wdata = req_q1[0].wdata;
            end else begin
                m1_req = 0; m1_addr = 0; m1_we = 0; m1_be = 0; m1_wdata = 0;
            end
        end
    end

    // Target model: records accepted requests, answers tgt_lat cycles later with ~addr.
    initial begin
        s_rvalid = 0;
        s_rdata  = 0;
        forever begin
            @(negedge clk);
            if (s_req && s_gnt) tgt_q.push_back({32'(cyc + tgt_lat), ~s_addr});
            @(posedge clk);
            #3;
            if (tgt_q.size() != 0 && tgt_q[0].due <= 32'(cyc)) begin
                s_rvalid = 1;
                s_rdata  = tgt_q[0].data;
                void'(tgt_q.pop_front());
            end else begin
                s_rvalid = inj_rvalid;
                s_rdata  = inj_rvalid ? 32'hDEAD_BEEF : 32'h0;
            end
        end
    end

    // Fixed-priority instance target: answer one cycle after each grant.
    initial begin
        fp_s_rvalid = 0;
        fp_prev     = 0;
        forever begin
            @(negedge clk);
            fp_prev = fp_m0_gnt | fp_m1_gnt;
            @(posedge clk);
            #3;
            fp_s_rvalid = fp_prev;
        end
    end

    // Monitor: pops scoreboard entries whenever the DUT grants or responds.
    initial begin
        gexp_t e;
        logic [31:0] r;
        forever begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                if (exp_g_q.size() == 0) begin
                    unexp("unexpected_gnt");
                end else begin
                    e = exp_g_q.pop_front();
                    chk("gnt_id", 32'(m1_gnt), 32'(e.id));
                    chk("gnt_both", 32'(m0_gnt & m1_gnt), 32'd0);
                    chk("gnt_addr", s_addr, e.t.addr);
                    chk("gnt_we", 32'(s_we), 32'(e.t.we));
                    chk("gnt_be", 32'(s_be), 32'(e.t.be));
                    chk("gnt_wdata", s_wdata, e.t.wdata);
                end
                gnt_cyc_q.push_back(cyc);
                if (m0_gnt && req_q0.size() != 0) void'(req_q0.pop_front());
                if (m1_gnt && req_q1.size() != 0) void'(req_q1.pop_front());
            end
            if (m0_rvalid) begin
                if (exp_r0_q.size() == 0) unexp("unexpected_m0_rvalid");
                else begin r = exp_r0_q.pop_front(); chk("m0_rdata", m0_rdata, r); end
            end
            if (m1_rvalid) begin
                if (exp_r1_q.size() == 0) unexp("unexpected_m1_rvalid");
                else begin r = exp_r1_q.pop_front(); chk("m1_rdata", m1_rdata, r); end
            end
        end
    end

    initial begin
        int n;
        rst = 1; s_gnt = 0; fp_m0_req = 0; fp_m1_req = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        // Reset state: every output idle.
        @(negedge clk);
        chk("rst_s_req", 32'(s_req), 0);
        chk("rst_gnt", 32'({m0_gnt, m1_gnt}), 0);
        chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
        chk("rst_perr", 32'(perr), 0);
        chk("rst_s_addr", s_addr, 0);

        // Core only, three back-to-back reads.
        gnt_cyc_q.delete();
        @(posedge clk); #1;
        s_gnt = 1;
        issue(0, 32'h100, 0, 4'hF, 0);
        issue(0, 32'h104, 0, 4'hF, 0);
        issue(0, 32'h108, 0, 4'hF, 0);
        wait_idle("t1_drain");
        chk("t1_gnt_count", 32'(gnt_cyc_q.size()), 3);
        if (gnt_cyc_q.size() == 3) begin
            chk("t1_consec_a", 32'(gnt_cyc_q[1] - gnt_cyc_q[0]), 1);
            chk("t1_consec_b", 32'(gnt_cyc_q[2] - gnt_cyc_q[1]), 1);
        end

        // Grant held off: m0 address frozen even though m1 is favoured by round-robin.
        @(posedge clk); #1;
        s_gnt = 0;
        issue(0, 32'h400, 0, 4'hF, 0);
        @(negedge clk);
        chk("hold_addr0", s_addr, 32'h400);
        @(posedge clk); #1;
        issue(1, 32'h500, 0, 4'hF, 0);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("hold_addr", s_addr, 32'h400);
            chk("hold_req", 32'(s_req), 1);
            if (i < 3) @(posedge clk);
        end
        @(posedge clk); #1;
        s_gnt = 1;
        wait_idle("hold_drain");

        // Round-robin with both requesting; third attempt blocked by a full FIFO.
        gnt_cyc_q.delete();
        tgt_lat = 2;
        @(posedge clk); #1;
        issue(0, 32'h200, 1, 4'b0011, 32'h1111_2222);
        issue(1, 32'h300, 0, 4'hF, 0);
        issue(0, 32'h204, 0, 4'hF, 0);
        issue(1, 32'h304, 1, 4'b1100, 32'h3333_4444);
        repeat (3) @(negedge clk);
        chk("full_s_req", 32'(s_req), 0);
        chk("full_gnt", 32'({m0_gnt, m1_gnt}), 0);
        wait_idle("rr_drain");
        chk("rr_gnt_count", 32'(gnt_cyc_q.size()), 4);
        if (gnt_cyc_q.size() == 4) begin
            chk("rr_gap1", 32'(gnt_cyc_q[1] - gnt_cyc_q[0]), 1);
            chk("rr_gap2", 32'(gnt_cyc_q[2] - gnt_cyc_q[1]), 2);
            chk("rr_gap3", 32'(gnt_cyc_q[3] - gnt_cyc_q[2]), 1);
        end

        // Response with empty FIFO sets a sticky error.
        tgt_lat = 1;
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("empty_perr_pre", 32'(perr), 0);
        @(posedge clk); #1 inj_rvalid = 1;
        @(negedge clk);
        chk("empty_perr_same", 32'(perr), 0);
        @(posedge clk); #1 inj_rvalid = 0;
        @(negedge clk);
        chk("empty_perr_next", 32'(perr), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("empty_perr_sticky", 32'(perr), 1);

        // Reset with two outstanding; late responses are dropped and flagged.
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst2_perr_clear", 32'(perr), 0);
        tgt_lat = 6;
        @(posedge clk); #1;
        issue(0, 32'h600, 0, 4'hF, 0);
        issue(0, 32'h604, 0, 4'hF, 0);
        n = 0;
        while (exp_g_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
        chk("rst2_granted", 32'(n < 50), 1);
        @(negedge clk);
        chk("rst2_count_pre", 32'(dut.fifo_count), 2);
        @(posedge clk); #1 rst = 1;
        exp_r0_q.delete();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst2_count_post", 32'(dut.fifo_count), 0);
        chk("rst2_perr_post", 32'(perr), 0);
        n = 0;
        while (tgt_q.size() != 0 && n < 50) begin @(posedge clk); n++; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst2_perr_late", 32'(perr), 1);
        @(posedge clk); #1 rst = 1;
        tgt_q.delete();
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("final_perr_clear", 32'(perr), 0);

        // Fixed priority: debug wins every cycle while requesting.
        @(posedge clk); #1;
        fp_m0_req = 1; fp_m1_req = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fp_m1_gnt", 32'(fp_m1_gnt), 1);
            chk("fp_m0_gnt", 32'(fp_m0_gnt), 0);
            if (i > 0) chk("fp_m1_rvalid", 32'({fp_m1_rvalid, fp_m0_rvalid}), 32'b10);
            @(posedge clk);
        end
        #1 fp_m1_req = 0;
        @(negedge clk);
        chk("fp_m0_gnt_after", 32'(fp_m0_gnt), 1);
        @(posedge clk); #1 fp_m0_req = 0;
        @(negedge clk);
        chk("fp_m0_rvalid", 32'({fp_m1_rvalid, fp_m0_rvalid}), 32'b01);
        chk("fp_m0_rdata", fp_m0_rdata, 32'h0000_5A5A);
        chk("fp_perr", 32'(fp_perr), 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
